// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: core load/store (port 0) and loader/debug (port 1).
// Round-robin on contention, optional per-port lock, registered read return.
module dmem_arbiter #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int WEW = DW / 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           p0_req,
    input  logic           p0_lock,
    input  logic [WEW-1:0] p0_we,
    input  logic [AW-1:0]  p0_addr,
    input  logic [DW-1:0]  p0_wdata,
    output logic           p0_gnt,
    output logic           p0_rvalid,
    output logic [DW-1:0]  p0_rdata,
    input  logic           p1_req,
    input  logic           p1_lock,
    input  logic [WEW-1:0] p1_we,
    input  logic [AW-1:0]  p1_addr,
    input  logic [DW-1:0]  p1_wdata,
    output logic           p1_gnt,
    output logic           p1_rvalid,
    output logic [DW-1:0]  p1_rdata,
    output logic [AW-1:0]  mem_addr,
    output logic [DW-1:0]  mem_din,
    output logic [WEW-1:0] mem_we,
    input  logic [DW-1:0]  mem_dout,
    output logic [15:0]    conflict_cnt
);

    typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;

    state_t          state_q, state_d;
    logic            last_gnt_q, last_gnt_d;   // 0: port 0 last granted, 1: port 1
    logic            g0, g1;
    logic            rv0_q, rv1_q;
    logic [DW-1:0]   rdata0_q, rdata1_q;
    logic [15:0]     cnt_q;
    logic            rd0, rd1;

    // Grant selection and next state; a held lock bypasses arbitration entirely.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        g0         = 1'b0;
        g1         = 1'b0;
        if (reset) begin
            // no grants while in reset
        end else if (state_q == LOCK0 && p0_lock) begin
            g0 = p0_req;
        end else if (state_q == LOCK1 && p1_lock) begin
            g1 = p1_req;
        end else begin
            // Plain arbitration, also used on the cycle a lock is released.
            if (p0_req && p1_req) begin
                g0 = last_gnt_q;
                g1 = ~last_gnt_q;
            end else begin
                g0 = p0_req;
                g1 = p1_req;
            end
            state_d = ARB;
            if (g0 && p0_lock)      state_d = LOCK0;
            else if (g1 && p1_lock) state_d = LOCK1;
        end
        if (g0) last_gnt_d = 1'b0;
        if (g1) last_gnt_d = 1'b1;
    end

    assign p0_gnt   = g0;
    assign p1_gnt   = g1;
    assign mem_we   = g1 ? p1_we : (g0 ? p0_we : '0);
    assign mem_addr = g1 ? p1_addr  : p0_addr;
    assign mem_din  = g1 ? p1_wdata : p0_wdata;

    assign rd0 = g0 && (p0_we == '0);
    assign rd1 = g1 && (p1_we == '0);

    // State, read-return registers and saturating conflict counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB;
            last_gnt_q <= 1'b1;
            rv0_q      <= 1'b0;
            rv1_q      <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            rv0_q      <= rd0;
            rv1_q      <= rd1;
            if (rd0) rdata0_q <= mem_dout;
            if (rd1) rdata1_q <= mem_dout;
            if (p0_req && p1_req && (g0 ^ g1) && cnt_q != 16'hFFFF)
                cnt_q <= cnt_q + 16'd1;
        end
    end

    // A reset arriving the cycle after a read grant suppresses that return.
    assign p0_rvalid    = rv0_q & ~reset;
    assign p1_rvalid    = rv1_q & ~reset;
    assign p0_rdata     = rdata0_q;
    assign p1_rdata     = rdata1_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed stimulus, read returns checked by a scoreboard monitor.
module tb_dmem_arbiter;

    logic        clk, reset;
    logic        p0_req, p0_lock, p1_req, p1_lock;
    logic [3:0]  p0_we, p1_we, mem_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_din, mem_dout;
    logic [15:0] conflict_cnt;

    int total = 0;
    int bad   = 0;
    logic [32:0] sb[$];   // {port, data}
    logic [31:0] tbmem [0:255];

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_lock(p0_lock), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_lock(p1_lock), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
        .conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-addressed memory model with byte enables, combinational read.
    assign mem_dout = tbmem[mem_addr[9:2]];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (mem_we[b]) tbmem[mem_addr[9:2]][8*b +: 8] <= mem_din[8*b +: 8];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_p0(input logic req, input logic lock, input logic [3:0] we,
                          input logic [31:0] addr, input logic [31:0] wdata);
        p0_req = req; p0_lock = lock; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    endtask

    task automatic set_p1(input logic req, input logic lock, input logic [3:0] we,
                          input logic [31:0] addr, input logic [31:0] wdata);
        p1_req = req; p1_lock = lock; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    endtask

    task automatic do_reset();
        set_p0(0, 0, 4'h0, 32'h0, 32'h0);
        set_p1(0, 0, 4'h0, 32'h0, 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    // Monitor: every read return must match the oldest scoreboard entry.
    always @(negedge clk) begin
        logic [32:0] e;
        if (p0_rvalid && p1_rvalid) chk("rvalid_both", 32'd1, 32'd0);
        if (p0_rvalid || p1_rvalid) begin
            if (sb.size() == 0) begin
                chk("rvalid_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rv_port", {31'b0, p1_rvalid}, {31'b0, e[32]});
                chk("rdata", p1_rvalid ? p1_rdata : p0_rdata, e[31:0]);
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) tbmem[i] = 32'h0;
        tbmem[32'h10 >> 2] = 32'hDEADBEEF;
        tbmem[32'h14 >> 2] = 32'hCAFEF00D;
        tbmem[32'h40 >> 2] = 32'h55667788;

        // Reset held two cycles with both requesting.
        reset = 1'b1;
        set_p0(1, 1, 4'h0, 32'h10, 32'h0);
        set_p1(1, 1, 4'hF, 32'h20, 32'h1);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_gnt0", {31'b0, p0_gnt}, 32'd0);
            chk("rst_gnt1", {31'b0, p1_gnt}, 32'd0);
            chk("rst_mem_we", {28'b0, mem_we}, 32'd0);
            chk("rst_rvalid", {30'b0, p0_rvalid, p1_rvalid}, 32'd0);
            chk("rst_cnt", {16'b0, conflict_cnt}, 32'd0);
            chk("rst_rdata", p0_rdata | p1_rdata, 32'd0);
        end
        set_p0(0, 0, 4'h0, 32'h0, 32'h0);
        set_p1(0, 0, 4'h0, 32'h0, 32'h0);
        reset = 1'b0;
        tick();

        // Single read from port 0.
        set_p0(1, 0, 4'h0, 32'h10, 32'h0);
        #1;
        chk("rd_gnt0", {31'b0, p0_gnt}, 32'd1);
        chk("rd_gnt1", {31'b0, p1_gnt}, 32'd0);
        chk("rd_addr", mem_addr, 32'h10);
        chk("rd_we", {28'b0, mem_we}, 32'd0);
        sb.push_back({1'b0, 32'hDEADBEEF});
        tick();
        set_p0(0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("rd_rvalid0", {31'b0, p0_rvalid}, 32'd1);
        chk("rd_rvalid1", {31'b0, p1_rvalid}, 32'd0);
        chk("rd_rdata0", p0_rdata, 32'hDEADBEEF);
        tick();
        chk("rd_rvalid_once", {31'b0, p0_rvalid}, 32'd0);

        // Contention: alternating grants starting with port 0.
        do_reset();
        set_p0(1, 0, 4'h0, 32'h10, 32'h0);
        set_p1(1, 0, 4'h0, 32'h14, 32'h0);
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("ct_gnt0", {31'b0, p0_gnt}, (c % 2 == 0) ? 32'd1 : 32'd0);
            chk("ct_gnt1", {31'b0, p1_gnt}, (c % 2 == 1) ? 32'd1 : 32'd0);
            if (c % 2 == 0) sb.push_back({1'b0, 32'hDEADBEEF});
            else            sb.push_back({1'b1, 32'hCAFEF00D});
            tick();
        end
        set_p0(0, 0, 4'h0, 32'h0, 32'h0);
        set_p1(0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("ct_cnt", {16'b0, conflict_cnt}, 32'd4);
        tick();

        // Lock: port 1 owns the memory for four writes while port 0 waits.
        do_reset();
        set_p1(1, 1, 4'hF, 32'h20, 32'h11223344);
        #1;
        chk("lk_gnt1_first", {31'b0, p1_gnt}, 32'd1);
        chk("lk_din", mem_din, 32'h11223344);
        chk("lk_we", {28'b0, mem_we}, 32'hF);
        tick();
        set_p0(1, 0, 4'h0, 32'h10, 32'h0);
        for (int c = 0; c < 3; c++) begin
            set_p1(1, 1, 4'hF, 32'h24 + 32'(4 * c), 32'(c + 1));
            #1;
            chk("lk_gnt0_blocked", {31'b0, p0_gnt}, 32'd0);
            chk("lk_gnt1", {31'b0, p1_gnt}, 32'd1);
            tick();
        end
        set_p1(1, 0, 4'hF, 32'h30, 32'h99);
        #1;
        chk("lk_release_gnt0", {31'b0, p0_gnt}, 32'd1);
        chk("lk_release_gnt1", {31'b0, p1_gnt}, 32'd0);
        sb.push_back({1'b0, 32'hDEADBEEF});
        tick();
        set_p0(0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("lk_after_gnt1", {31'b0, p1_gnt}, 32'd1);
        tick();
        set_p1(0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("lk_cnt", {16'b0, conflict_cnt}, 32'd4);
        chk("lk_mem20", tbmem[32'h20 >> 2], 32'h11223344);
        chk("lk_mem30", tbmem[32'h30 >> 2], 32'h99);

        // Byte write then read-back.
        set_p0(1, 0, 4'b0010, 32'h40, 32'h0000AB00);
        #1;
        chk("bw_gnt0", {31'b0, p0_gnt}, 32'd1);
        chk("bw_we", {28'b0, mem_we}, 32'b0010);
        tick();
        set_p0(1, 0, 4'h0, 32'h40, 32'h0);
        #1;
        chk("bw_rd_gnt0", {31'b0, p0_gnt}, 32'd1);
        sb.push_back({1'b0, 32'h5566AB88});
        tick();
        set_p0(0, 0, 4'h0, 32'h0, 32'h0);
        tick();

        // Counter saturation under continuous contention (writes, no returns).
        do_reset();
        set_p0(1, 0, 4'hF, 32'h80, 32'h1);
        set_p1(1, 0, 4'hF, 32'h84, 32'h2);
        for (int c = 0; c < 65534; c++) tick();
        chk("sat_fffe", {16'b0, conflict_cnt}, 32'hFFFE);
        tick();
        chk("sat_ffff", {16'b0, conflict_cnt}, 32'hFFFF);
        tick();
        tick();
        chk("sat_hold", {16'b0, conflict_cnt}, 32'hFFFF);
        set_p1(0, 0, 4'h0, 32'h0, 32'h0);

        // Reset in the cycle after a read grant drops the return.
        set_p0(1, 0, 4'h0, 32'h10, 32'h0);
        #1;
        chk("mr_gnt0", {31'b0, p0_gnt}, 32'd1);
        tick();
        set_p0(0, 0, 4'h0, 32'h0, 32'h0);
        reset = 1'b1;
        #1;
        chk("mr_no_rvalid", {31'b0, p0_rvalid}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("mr_no_rvalid_late", {31'b0, p0_rvalid}, 32'd0);
        chk("mr_cnt", {16'b0, conflict_cnt}, 32'd0);

        tick();
        tick();
        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
